// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite definitions for the responder and the initiator.
//   - response codes
//   - write/read handshake FSM state encodings
//   - held write-beat struct
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic { W_IDLE, W_RESP } wr_state_e;
  typedef enum logic { R_IDLE, R_DATA } rd_state_e;

  // W beat captured when data arrives ahead of its address.
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } wbeat_t;

endpackage

// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: NUM_REGS x 32-bit register storage.
// Ports:
//   ACLK, ARESETn      clock, synchronous active-low reset (clears all registers)
//   we/widx/wdata/wstrb one byte-strobed write port, applied at the rising edge
//   ridx -> rdata       combinational read port (returns the pre-edge value)
//   reg_out             all registers flattened, register i at [32*i+31:32*i]
module axi_lite_regfile #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     we,
  input  logic [IDX_W-1:0]         widx,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic [IDX_W-1:0]         ridx,
  output logic [31:0]              rdata,
  output logic [NUM_REGS*32-1:0]   reg_out
);

  logic [NUM_REGS-1:0][31:0] regs;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      regs <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) regs[widx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata   = regs[ridx];
  assign reg_out = regs;

endmodule

// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs: AXI4-Lite responder exposing a NUM_REGS x 32-bit register file.
// Ports:
//   ACLK, ARESETn                 clock, synchronous active-low reset
//   S_AXI_AW*/W*/B*               write address / data / response channels
//   S_AXI_AR*/R*                  read address / data channels
//   REG_OUT                       flat register contents for downstream control
// Address index = addr[IDX_W+1:2]; byte offset bits ignored.
// Optional: define AXIL_SLAVE_RANGE_CHECK_EN to answer SLVERR for addresses with
// any bit above the index set (no write, RDATA=0). Undefined: addresses alias.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_W-1:0]       S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [31:0]             S_AXI_WDATA,
  input  logic [3:0]              S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_W-1:0]       S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [31:0]             S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]  REG_OUT
);

  // ---------------- write path state ----------------
  wr_state_e         w_state_q, w_state_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  wbeat_t            wbeat_q, wbeat_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;

  // ---------------- read path state ----------------
  rd_state_e         r_state_q, r_state_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  // regfile ports
  logic              reg_we;
  logic [31:0]       reg_rdata;

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = S_AXI_AWVALID && awready_q;
  assign w_hs  = S_AXI_WVALID  && wready_q;
  assign ar_hs = S_AXI_ARVALID && arready_q;

  // Same-cycle handshakes bypass the holding registers so the commit lands on
  // the edge of the later handshake.
  logic [ADDR_W-1:0] wr_addr;
  wbeat_t            wr_beat;
  assign wr_addr = aw_hs ? S_AXI_AWADDR : awaddr_q;
  assign wr_beat = w_hs  ? '{data: S_AXI_WDATA, strb: S_AXI_WSTRB} : wbeat_q;

  logic wr_oor, rd_oor;
`ifdef AXIL_SLAVE_RANGE_CHECK_EN
  assign wr_oor = |wr_addr[ADDR_W-1:IDX_W+2];
  assign rd_oor = |S_AXI_ARADDR[ADDR_W-1:IDX_W+2];
`else
  assign wr_oor = 1'b0;
  assign rd_oor = 1'b0;
`endif

  // Bits outside the index are only consumed when range checking is built in.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr, S_AXI_ARADDR};

  axi_lite_regfile #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_regfile (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .we      (reg_we),
    .widx    (wr_addr[IDX_W+1:2]),
    .wdata   (wr_beat.data),
    .wstrb   (wr_beat.strb),
    .ridx    (S_AXI_ARADDR[IDX_W+1:2]),
    .rdata   (reg_rdata),
    .reg_out (REG_OUT)
  );

  // ---------------- write FSM ----------------
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wbeat_d   = wbeat_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    reg_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = S_AXI_AWADDR;
          awready_d = 1'b0;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wbeat_d  = wr_beat;
          wready_d = 1'b0;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          reg_we    = !wr_oor;
          bvalid_d  = 1'b1;
          bresp_d   = wr_oor ? RESP_SLVERR : RESP_OKAY;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid_q && S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wbeat_q   <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wbeat_q   <= wbeat_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // ---------------- read FSM ----------------
  // reg_rdata is sampled before any same-edge write lands: collisions return old data.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_d   = rd_oor ? 32'h0 : reg_rdata;
          rresp_d   = rd_oor ? RESP_SLVERR : RESP_OKAY;
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs: directed scenarios plus random
// traffic, all checked against an array-based register model.
module tb_axi_lite_slave_regs;

  localparam int ADDR_W   = 32;
  localparam int NUM_REGS = 8;
  localparam int IDX_W    = $clog2(NUM_REGS);

  logic                   ACLK, ARESETn;
  logic [ADDR_W-1:0]      AWADDR, ARADDR;
  logic                   AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic                   ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0]            WDATA, RDATA;
  logic [3:0]             WSTRB;
  logic [1:0]             BRESP, RRESP;
  logic [NUM_REGS*32-1:0] REG_OUT;

  axi_lite_slave_regs #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .REG_OUT(REG_OUT)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [NUM_REGS];

  // ---------------- reference model ----------------
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  function automatic bit in_range(input logic [ADDR_W-1:0] a);
`ifdef AXIL_SLAVE_RANGE_CHECK_EN
    return (a >> (IDX_W + 2)) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int idx_of(input logic [ADDR_W-1:0] a);
    return int'((a >> 2) % NUM_REGS);
  endfunction

  function automatic logic [NUM_REGS*32-1:0] model_flat();
    logic [NUM_REGS*32-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[32*i +: 32] = model[i];
    return f;
  endfunction

  function automatic void model_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    if (in_range(a)) model[idx_of(a)] = merge(model[idx_of(a)], d, s);
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Full write: AW and W presented together, waits for both handshakes, then B.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp);
    bit aw_done, w_done, aw_now, w_now;
    int t;
    aw_done = 0; w_done = 0; t = 0;
    AWADDR = a; AWVALID = 1; WDATA = d; WSTRB = s; WVALID = 1; BREADY = 1;
    while (!(aw_done && w_done) && t < 50) begin
      aw_now = AWVALID && AWREADY;
      w_now  = WVALID && WREADY;
      tick();
      if (aw_now) begin aw_done = 1; AWVALID = 0; end
      if (w_now)  begin w_done = 1;  WVALID = 0;  end
      t++;
    end
    AWVALID = 0; WVALID = 0;
    n_cmp++;
    if (!(aw_done && w_done) || BVALID !== 1'b1) begin
      n_err++;
      $display("FAIL wr_handshake addr=%h: aw=%0d w=%0d bvalid=%b, required all 1", a, aw_done, w_done, BVALID);
    end
    resp = BRESP;
    model_write(a, d, s);
    tick();
    BREADY = 0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [31:0] d,
                         output logic [1:0] resp);
    bit ar_now, done;
    int t;
    done = 0; t = 0;
    ARADDR = a; ARVALID = 1; RREADY = 1;
    while (!done && t < 50) begin
      ar_now = ARVALID && ARREADY;
      tick();
      if (ar_now) done = 1;
      t++;
    end
    ARVALID = 0;
    n_cmp++;
    if (!done || RVALID !== 1'b1) begin
      n_err++;
      $display("FAIL rd_handshake addr=%h: ar=%0d rvalid=%b, required 1/1", a, done, RVALID);
    end
    d = RDATA;
    resp = RRESP;
    tick();
    RREADY = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
    AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0;
    ARESETn = 0;
    tick(); tick();
    ARESETn = 1;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    n_cmp++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      n_err++; $display("FAIL reset_ready: got %b, required 111", {AWREADY, WREADY, ARREADY});
    end
    n_cmp++;
    if ({BVALID, RVALID, BRESP, RRESP} !== 6'b0 || RDATA !== 32'h0) begin
      n_err++; $display("FAIL reset_resp: bv=%b rv=%b br=%b rr=%b rd=%h, required zeros", BVALID, RVALID, BRESP, RRESP, RDATA);
    end
    n_cmp++;
    if (REG_OUT !== model_flat()) begin
      n_err++; $display("FAIL reset_regs: got %h, required %h", REG_OUT, model_flat());
    end
  endtask

  task automatic test_same_cycle();
    logic [1:0] r; logic [31:0] d;
    do_write(32'h4, 32'h12345678, 4'hF, r);
    n_cmp++;
    if (r !== 2'b00) begin n_err++; $display("FAIL same_bresp: got %b, required 00", r); end
    n_cmp++;
    if (REG_OUT[63:32] !== model[1]) begin
      n_err++; $display("FAIL same_regout: got %h, required %h", REG_OUT[63:32], model[1]);
    end
    do_read(32'h4, d, r);
    n_cmp++;
    if (d !== model[1] || r !== 2'b00) begin
      n_err++; $display("FAIL same_read: got %h/%b, required %h/00", d, r, model[1]);
    end
  endtask

  task automatic test_w_before_aw();
    WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1; BREADY = 1;
    tick();
    WVALID = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin AWADDR = 32'h8; AWVALID = 1; end
      n_cmp++;
      if (WREADY !== 1'b0 || BVALID !== 1'b0) begin
        n_err++; $display("FAIL wfirst_wait c=%0d: wready=%b bvalid=%b, required 0/0", c, WREADY, BVALID);
      end
      tick();
    end
    AWVALID = 0;
    model_write(32'h8, 32'hDEADBEEF, 4'hF);
    n_cmp++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00 || REG_OUT[95:64] !== model[2]) begin
      n_err++; $display("FAIL wfirst_commit: bv=%b br=%b reg2=%h, required 1/00/%h", BVALID, BRESP, REG_OUT[95:64], model[2]);
    end
    tick();
    BREADY = 0;
  endtask

  task automatic test_strobe();
    logic [1:0] r;
    do_write(32'h4, 32'h12345678, 4'hF, r);
    do_write(32'h4, 32'hAABBCCDD, 4'b0101, r);
    n_cmp++;
    if (REG_OUT[63:32] !== 32'h12BB56DD || REG_OUT[63:32] !== model[1]) begin
      n_err++; $display("FAIL strobe_0101: got %h, required %h", REG_OUT[63:32], model[1]);
    end
    do_write(32'h4, 32'hFFFFFFFF, 4'b0000, r);
    n_cmp++;
    if (REG_OUT[63:32] !== model[1] || r !== 2'b00) begin
      n_err++; $display("FAIL strobe_zero: got %h/%b, required %h/00", REG_OUT[63:32], r, model[1]);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] held_resp;
    logic [31:0] held_data;
    AWADDR = 32'hC; WDATA = 32'h0BADF00D; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
    tick();
    model_write(32'hC, 32'h0BADF00D, 4'hF);
    held_resp = 2'b00;
    // Second write waits on the channels for the whole stall.
    AWADDR = 32'h10; WDATA = 32'h600DCAFE;
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (BVALID !== 1'b1 || BRESP !== held_resp || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
        n_err++; $display("FAIL bstall c=%0d: bv=%b br=%b awr=%b wr=%b, required 1/%b/0/0", c, BVALID, BRESP, AWREADY, WREADY, held_resp);
      end
      tick();
    end
    BREADY = 1;
    tick();
    n_cmp++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b1 || REG_OUT[159:128] !== model[4]) begin
      n_err++; $display("FAIL brelease: bv=%b awr=%b reg4=%h, required 0/1/%h", BVALID, AWREADY, REG_OUT[159:128], model[4]);
    end
    tick();
    AWVALID = 0; WVALID = 0;
    model_write(32'h10, 32'h600DCAFE, 4'hF);
    n_cmp++;
    if (BVALID !== 1'b1 || REG_OUT !== model_flat()) begin
      n_err++; $display("FAIL bsecond: bv=%b regs=%h, required 1/%h", BVALID, REG_OUT, model_flat());
    end
    tick();
    BREADY = 0;
    // Read stall.
    ARADDR = 32'hC; ARVALID = 1; RREADY = 0;
    tick();
    ARVALID = 0;
    held_data = model[3];
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (RVALID !== 1'b1 || RDATA !== held_data || RRESP !== 2'b00 || ARREADY !== 1'b0) begin
        n_err++; $display("FAIL rstall c=%0d: rv=%b rd=%h rr=%b arr=%b, required 1/%h/00/0", c, RVALID, RDATA, RRESP, ARREADY, held_data);
      end
      tick();
    end
    RREADY = 1;
    tick();
    RREADY = 0;
    n_cmp++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      n_err++; $display("FAIL rrelease: rv=%b arr=%b, required 0/1", RVALID, ARREADY);
    end
  endtask

  task automatic test_collision();
    logic [1:0] r; logic [31:0] d, old;
    do_write(32'hC, 32'h0, 4'hF, r);
    old = model[3];
    AWADDR = 32'hC; WDATA = 32'h1; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 1;
    ARADDR = 32'hC; ARVALID = 1; RREADY = 0;
    tick();
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    model_write(32'hC, 32'h1, 4'hF);
    n_cmp++;
    if (RVALID !== 1'b1 || RDATA !== old || BVALID !== 1'b1) begin
      n_err++; $display("FAIL collide_old: rv=%b rd=%h bv=%b, required 1/%h/1", RVALID, RDATA, BVALID, old);
    end
    RREADY = 1;
    tick();
    RREADY = 0; BREADY = 0;
    do_read(32'hC, d, r);
    n_cmp++;
    if (d !== model[3]) begin
      n_err++; $display("FAIL collide_new: got %h, required %h", d, model[3]);
    end
  endtask

  task automatic test_range();
    logic [1:0] r, er; logic [31:0] d, ed;
    do_write(32'h40, 32'hCAFEF00D, 4'hF, r);
    er = in_range(32'h40) ? 2'b00 : 2'b10;
    n_cmp++;
    if (r !== er || REG_OUT !== model_flat()) begin
      n_err++; $display("FAIL range_wr: resp=%b regs=%h, required %b/%h", r, REG_OUT, er, model_flat());
    end
    do_read(32'h40, d, r);
    ed = in_range(32'h40) ? model[0] : 32'h0;
    n_cmp++;
    if (r !== er || d !== ed) begin
      n_err++; $display("FAIL range_rd: got %h/%b, required %h/%b", d, r, ed, er);
    end
  endtask

  task automatic test_random();
    logic [1:0] r, er; logic [31:0] d, ed, a;
    for (int n = 0; n < 80; n++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'h1F);
      er = in_range(a) ? 2'b00 : 2'b10;
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, $urandom(), 4'($urandom()), r);
        n_cmp++;
        if (r !== er) begin n_err++; $display("FAIL rand_bresp a=%h: got %b, required %b", a, r, er); end
      end else begin
        ed = in_range(a) ? model[idx_of(a)] : 32'h0;
        do_read(a, d, r);
        n_cmp++;
        if (d !== ed || r !== er) begin
          n_err++; $display("FAIL rand_read a=%h: got %h/%b, required %h/%b", a, d, r, ed, er);
        end
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    n_cmp++;
    if (REG_OUT !== model_flat()) begin
      n_err++; $display("FAIL rand_regs: got %h, required %h", REG_OUT, model_flat());
    end
  endtask

  task automatic test_reset_mid();
    // W held alone plus a pending read, then reset.
    WDATA = 32'h77777777; WSTRB = 4'hF; WVALID = 1;
    ARADDR = 32'h4; ARVALID = 1; RREADY = 0; BREADY = 1;
    tick();
    WVALID = 0; ARVALID = 0;
    ARESETn = 0;
    tick();
    ARESETn = 1;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    n_cmp++;
    if (RVALID !== 1'b0 || BVALID !== 1'b0 || WREADY !== 1'b1 || REG_OUT !== model_flat()) begin
      n_err++; $display("FAIL rstmid_state: rv=%b bv=%b wr=%b regs=%h, required 0/0/1/zeros", RVALID, BVALID, WREADY, REG_OUT);
    end
    // Address alone must not pair with the discarded data.
    AWADDR = 32'h4; AWVALID = 1;
    tick();
    AWVALID = 0;
    tick();
    n_cmp++;
    if (BVALID !== 1'b0 || REG_OUT !== model_flat()) begin
      n_err++; $display("FAIL rstmid_discard: bv=%b regs=%h, required 0/zeros", BVALID, REG_OUT);
    end
    WDATA = 32'h00005555; WVALID = 1;
    tick();
    WVALID = 0;
    model_write(32'h4, 32'h00005555, 4'hF);
    n_cmp++;
    if (BVALID !== 1'b1 || REG_OUT !== model_flat()) begin
      n_err++; $display("FAIL rstmid_complete: bv=%b regs=%h, required 1/%h", BVALID, REG_OUT, model_flat());
    end
    tick();
    BREADY = 0;
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_strobe();
    test_backpressure();
    test_collision();
    test_range();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
- AXI4-Lite responder for the AXI4-Lite initiator: a memory-mapped register file of NUM_REGS 32-bit registers.
- Accepts write address and write data independently, in either order, and returns one write response per write.
- Serves one read at a time with 1-cycle read latency.
- Register contents are exported as a flat bus for downstream control logic.

Parameters:
- ADDR_W, 32, address width of AWADDR/ARADDR.
- NUM_REGS, 8, number of 32-bit registers; power of two, minimum 2.
- IDX_W, $clog2(NUM_REGS), derived register index width; not overridden.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETn  in  1  synchronous, active-low reset.
- S_AXI_AWADDR  in  ADDR_W  write address.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  ADDR_W  read address.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- REG_OUT  out  NUM_REGS*32  register contents; register i occupies bits [32*i+31:32*i].

Behaviour:
- All outputs are registered.
- Reset (ARESETn=0 at an edge):
  - all registers = 0;
  - AWREADY, WREADY, ARREADY = 1;
  - BVALID, RVALID = 0;
  - BRESP, RRESP = 2'b00; RDATA = 0.
- Address decode: bits [1:0] ignored; index = addr[IDX_W+1:2].
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE, AW channel: AW handshake = AWVALID && AWREADY. On handshake, latch AWADDR, set aw_held, drop AWREADY.
  - W_IDLE, W channel: W handshake = WVALID && WREADY. On handshake, latch WDATA/WSTRB, set w_held, drop WREADY.
  - The commit happens at the edge where both address and data become available (held or handshaking this cycle, including the same cycle). At that edge:
    - update the target register; byte k is written only if WSTRB[k]=1;
    - BVALID=1 with BRESP;
    - clear aw_held/w_held;
    - go to W_RESP.
  - W_RESP: AWREADY=WREADY=0. When BVALID && BREADY, BVALID=0, AWREADY=WREADY=1, go to W_IDLE.
  - Latency: commit and BVALID at the same edge as the later of the two handshakes.
  - BVALID held stable until accepted, regardless of how long BREADY stays low.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: on ARVALID && ARREADY, at that edge RDATA = register[index], RRESP set, RVALID=1, ARREADY=0, go to R_DATA.
  - R_DATA: RDATA/RRESP stable. On RVALID && RREADY, RVALID=0, ARREADY=1, go to R_IDLE.
- Read and write paths are fully independent and may be active in the same cycle.
- Read/write collision: a read handshake at the same edge as a write commit to the same register returns the pre-write value.
- WSTRB=0: the handshake completes, no bytes change, BRESP=OKAY.
- Reset mid-transaction: pending BVALID/RVALID dropped and held address/data discarded; no register update.

Optional Feature:
- Macro AXIL_SLAVE_RANGE_CHECK_EN.
- Defined: an address with addr[ADDR_W-1:IDX_W+2] != 0 is out of range.
  - Out-of-range write: no register changes, BRESP=2'b10 (SLVERR).
  - Out-of-range read: RDATA=0, RRESP=2'b10.
- Undefined: upper address bits ignored, addresses alias modulo NUM_REGS*4, responses always 2'b00 (OKAY).

Decomposition:
- Shared package axi_lite_pkg: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11; write-state and read-state enums. The initiator also uses this package.
- One sub-module, axi_lite_regfile:
  - NUM_REGS x 32 storage;
  - one byte-strobed write port;
  - one combinational read port;
  - flat REG_OUT.
- The handshake FSMs and address decode stay in axi_lite_slave_regs.

Test Plan:
- AW 0x4 and W 0x12345678/4'hF in the same cycle, BREADY=1 → BVALID the next cycle with BRESP=00; REG_OUT[63:32]=0x12345678. Then AR 0x4 → RVALID one cycle after the handshake, RDATA=0x12345678, RRESP=00.
- W before AW: W 0xDEADBEEF at cycle 2, AW 0x8 at cycle 5 → WREADY=0 during cycles 3-5; commit and BVALID at cycle 6 edge; register 2 = 0xDEADBEEF.
- Register 1 = 0x12345678, then write 0xAABBCCDD with WSTRB=4'b0101 → register 1 = 0x12BB56DD; WSTRB=0 → value unchanged, BRESP=00.
- BREADY held low for 10 cycles → BVALID and BRESP stable, AWREADY=WREADY=0 throughout; a new AW/W is accepted only after the B handshake. Same check for RVALID with RREADY held low.
- Read of register 3 with its AR handshake on the same edge as a write commit of 0x1 to register 3 (old value 0x0) → RDATA=0x0, and a following read returns 0x1.
- With AXIL_SLAVE_RANGE_CHECK_EN defined, NUM_REGS=8: write 0x40 → BRESP=10, no register changed; read 0x40 → RDATA=0, RRESP=10. Macro undefined: 0x40 aliases to register 0, OKAY.
